stream_sort_checker: RTL and testbench

STREAM_SORT_CHECKER -- requirements
Module: stream_sort_checker

---
 rtl/stream_sort_checker_if.sv | 23 ++
 rtl/stream_sort_checker.sv | 135 +++++++++++++
 tb/tb_stream_sort_checker.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/stream_sort_checker_if.sv
// Monitored sorter input/output AXI-Stream taps, bundled for the passive checker.
interface stream_sort_checker_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_tvalid;
   logic                  in_tready;
   logic                  in_tlast;
   logic [DATA_WIDTH-1:0] in_tdata;
   logic                  out_tvalid;
   logic                  out_tready;
   logic                  out_tlast;
   logic [DATA_WIDTH-1:0] out_tdata;

   modport master (
      output in_tvalid, in_tready, in_tlast, in_tdata,
      output out_tvalid, out_tready, out_tlast, out_tdata
   );

   modport slave (
      input in_tvalid, in_tready, in_tlast, in_tdata,
      input out_tvalid, out_tready, out_tlast, out_tdata
   );
endinterface

// File: rtl/stream_sort_checker.sv
// Passive checker for a frame sorter: verifies output ordering, frame lengths and
// that each output frame carries the same element sum as its matching input frame.
module stream_sort_checker #(
   parameter int DATA_WIDTH      = 8,
   parameter int ADDR_WIDTH      = 2,
   parameter int DESCENDING      = 0,
   parameter int SIGNED_CMP      = 0,
   parameter int FIFO_ADDR_WIDTH = 2,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   stream_sort_checker_if.slave mon,
   output logic                 frame_done,
   output logic                 frame_ok,
   output logic                 err_order,
   output logic                 err_len_in,
   output logic                 err_len_out,
   output logic                 err_sum,
   output logic                 err_fifo_ovf,
   output logic [CNT_WIDTH-1:0] frames_checked,
   output logic [CNT_WIDTH-1:0] frames_failed
);

   localparam int SW    = DATA_WIDTH + ADDR_WIDTH;
   localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

   function automatic logic signed [SW-1:0] ext_elem(input logic [DATA_WIDTH-1:0] d);
      logic s;
      s = (SIGNED_CMP != 0) && d[DATA_WIDTH-1];
      return $signed({{ADDR_WIDTH{s}}, d});
   endfunction

   function automatic logic order_bad(input logic [DATA_WIDTH-1:0] p,
                                      input logic [DATA_WIDTH-1:0] c);
      logic signed [DATA_WIDTH:0] ps;
      logic signed [DATA_WIDTH:0] cs;
      ps = $signed({(SIGNED_CMP != 0) && p[DATA_WIDTH-1], p});
      cs = $signed({(SIGNED_CMP != 0) && c[DATA_WIDTH-1], c});
      return (DESCENDING != 0) ? (ps < cs) : (ps > cs);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   logic                       in_fire, out_fire, in_close_p0, out_close_p0;
   logic                       in_len_bad_p0, out_len_bad_p0, ord_bad_p0, sum_bad_p0, fail_p0;
   logic [ADDR_WIDTH-1:0]      in_idx, out_idx;
   logic signed [SW-1:0]       in_acc, out_acc, in_sum_p0, out_sum_p0, head_p0;
   logic [DATA_WIDTH-1:0]      prev;
   logic                       out_bad;
   logic signed [SW-1:0]       mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [FIFO_ADDR_WIDTH:0]   count;
   logic                       fifo_empty, fifo_full, store, drop, deq, bypass;
   logic                       done_p1, ok_p1;

   // Stage p0: beat qualification, frame close detection and per-beat checks
   assign in_fire        = mon.in_tvalid && mon.in_tready && !rst;
   assign out_fire       = mon.out_tvalid && mon.out_tready && !rst;
   assign in_close_p0    = in_fire && (mon.in_tlast || (&in_idx));
   assign out_close_p0   = out_fire && (mon.out_tlast || (&out_idx));
   assign in_len_bad_p0  = in_close_p0 && (mon.in_tlast != (&in_idx));
   assign out_len_bad_p0 = out_close_p0 && (mon.out_tlast != (&out_idx));
   assign in_sum_p0      = in_acc + ext_elem(mon.in_tdata);
   assign out_sum_p0     = out_acc + ext_elem(mon.out_tdata);
   assign ord_bad_p0     = out_fire && (out_idx != '0) && order_bad(prev, mon.out_tdata);

   // An empty FIFO with a same-cycle push hands the fresh sum straight to the compare
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (FIFO_ADDR_WIDTH+1)'(DEPTH));
   assign bypass     = out_close_p0 && fifo_empty && in_close_p0;
   assign deq        = out_close_p0 && !fifo_empty;
   assign store      = in_close_p0 && !bypass && (!fifo_full || out_close_p0);
   assign drop       = in_close_p0 && fifo_full && !out_close_p0;
   assign head_p0    = fifo_empty ? in_sum_p0 : mem[rd_ptr];
   assign sum_bad_p0 = out_close_p0 && ((fifo_empty && !in_close_p0) || (head_p0 != out_sum_p0));
   assign fail_p0    = out_bad || ord_bad_p0 || out_len_bad_p0 || sum_bad_p0;

   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= in_sum_p0;
      if (out_fire) prev <= mon.out_tdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_idx         <= '0;
         in_acc         <= '0;
         out_idx        <= '0;
         out_acc        <= '0;
         out_bad        <= 1'b0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         done_p1        <= 1'b0;
         ok_p1          <= 1'b0;
         err_order      <= 1'b0;
         err_len_in     <= 1'b0;
         err_len_out    <= 1'b0;
         err_sum        <= 1'b0;
         err_fifo_ovf   <= 1'b0;
         frames_checked <= '0;
         frames_failed  <= '0;
      end else begin
         if (in_fire) begin
            in_idx <= in_close_p0 ? '0 : in_idx + ADDR_WIDTH'(1);
            in_acc <= in_close_p0 ? '0 : in_sum_p0;
         end
         if (out_fire) begin
            out_idx <= out_close_p0 ? '0 : out_idx + ADDR_WIDTH'(1);
            out_acc <= out_close_p0 ? '0 : out_sum_p0;
            out_bad <= out_close_p0 ? 1'b0 : (out_bad || ord_bad_p0);
         end
         if (store) wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
         if (deq)   rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
         count <= count + (FIFO_ADDR_WIDTH+1)'(store) - (FIFO_ADDR_WIDTH+1)'(deq);

         // Stage p1: registered frame verdict and sticky status
         done_p1      <= out_close_p0;
         ok_p1        <= out_close_p0 && !fail_p0;
         err_order    <= err_order || ord_bad_p0;
         err_len_in   <= err_len_in || in_len_bad_p0;
         err_len_out  <= err_len_out || out_len_bad_p0;
         err_sum      <= err_sum || sum_bad_p0;
         err_fifo_ovf <= err_fifo_ovf || drop;
         if (out_close_p0) frames_checked <= sat_inc(frames_checked);
         if (out_close_p0 && fail_p0) frames_failed <= sat_inc(frames_failed);
      end
   end

   assign frame_done = done_p1;
   assign frame_ok   = ok_p1;

endmodule

// File: tb/tb_stream_sort_checker.sv
// Directed bench: two checker instances (ascending/unsigned and descending/signed)
// watch the same stimulus; each scenario checks only the instance it targets.
module tb_stream_sort_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
   logic out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
   logic [7:0] in_tdata = '0, out_tdata = '0;
   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   stream_sort_checker_if #(.DATA_WIDTH(8)) ifa ();
   stream_sort_checker_if #(.DATA_WIDTH(8)) ifb ();

   assign ifa.in_tvalid = in_tvalid;   assign ifb.in_tvalid = in_tvalid;
   assign ifa.in_tready = in_tready;   assign ifb.in_tready = in_tready;
   assign ifa.in_tlast  = in_tlast;    assign ifb.in_tlast  = in_tlast;
   assign ifa.in_tdata  = in_tdata;    assign ifb.in_tdata  = in_tdata;
   assign ifa.out_tvalid = out_tvalid; assign ifb.out_tvalid = out_tvalid;
   assign ifa.out_tready = out_tready; assign ifb.out_tready = out_tready;
   assign ifa.out_tlast  = out_tlast;  assign ifb.out_tlast  = out_tlast;
   assign ifa.out_tdata  = out_tdata;  assign ifb.out_tdata  = out_tdata;

   logic done_a, ok_a, eo_a, eli_a, elo_a, es_a, ef_a;
   logic done_b, ok_b, eo_b, eli_b, elo_b, es_b, ef_b;
   logic [15:0] chk_a, fail_a, chk_b, fail_b;
   wire [4:0] errs_a = {eo_a, eli_a, elo_a, es_a, ef_a};
   wire [4:0] errs_b = {eo_b, eli_b, elo_b, es_b, ef_b};

   stream_sort_checker dut_a (
      .clk(clk), .rst(rst), .mon(ifa.slave),
      .frame_done(done_a), .frame_ok(ok_a),
      .err_order(eo_a), .err_len_in(eli_a), .err_len_out(elo_a),
      .err_sum(es_a), .err_fifo_ovf(ef_a),
      .frames_checked(chk_a), .frames_failed(fail_a)
   );

   stream_sort_checker #(.DESCENDING(1), .SIGNED_CMP(1)) dut_b (
      .clk(clk), .rst(rst), .mon(ifb.slave),
      .frame_done(done_b), .frame_ok(ok_b),
      .err_order(eo_b), .err_len_in(eli_b), .err_len_out(elo_b),
      .err_sum(es_b), .err_fifo_ovf(ef_b),
      .frames_checked(chk_b), .frames_failed(fail_b)
   );

   task automatic beat(input logic iv, input logic [7:0] id, input logic il,
                       input logic ov, input logic [7:0] od, input logic ol);
      in_tvalid = iv;  in_tready = 1'b1;  in_tdata = id;  in_tlast = il;
      out_tvalid = ov; out_tready = 1'b1; out_tdata = od; out_tlast = ol;
      @(negedge clk);
   endtask

   task automatic idle();
      in_tvalid = 1'b0; in_tlast = 1'b0; out_tvalid = 1'b0; out_tlast = 1'b0;
   endtask

   // Element 0 sits in the most significant byte of d.
   task automatic in_frame(input logic [31:0] d, input int n, input logic lastf);
      for (int i = 0; i < n; i++) beat(1'b1, d[31-8*i -: 8], lastf && (i == n-1), 1'b0, 8'h00, 1'b0);
      idle();
   endtask

   task automatic out_frame(input logic [31:0] d, input int n, input logic lastf);
      for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 1'b0, 1'b1, d[31-8*i -: 8], lastf && (i == n-1));
      idle();
   endtask

   task automatic both_frame(input logic [31:0] di, input logic [31:0] dout);
      for (int i = 0; i < 4; i++) beat(1'b1, di[31-8*i -: 8], i == 3, 1'b1, dout[31-8*i -: 8], i == 3);
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if ({done_a, ok_a} !== 2'b00) begin $display("FAIL reset_done_ok got=%b exp=00", {done_a, ok_a}); tests_failed++; end
      tests_run++; if (errs_a !== 5'b00000) begin $display("FAIL reset_errs got=%b exp=00000", errs_a); tests_failed++; end
      tests_run++; if ({chk_a, fail_a} !== 32'h0) begin $display("FAIL reset_counters got=%h exp=0", {chk_a, fail_a}); tests_failed++; end
   endtask

   task automatic test_sorted();
      in_frame(32'h04010302, 4, 1'b1);
      // Valid without ready must not be counted as a beat.
      out_tvalid = 1'b1; out_tready = 1'b0; out_tdata = 8'hFF; out_tlast = 1'b1;
      @(negedge clk);
      idle();
      out_frame(32'h01020304, 4, 1'b1);
      tests_run++; if ({done_a, ok_a} !== 2'b11) begin $display("FAIL sorted_done_ok got=%b exp=11", {done_a, ok_a}); tests_failed++; end
      tests_run++; if (chk_a !== 16'd1) begin $display("FAIL sorted_checked got=%0d exp=1", chk_a); tests_failed++; end
      tests_run++; if (errs_a !== 5'b00000) begin $display("FAIL sorted_errs got=%b exp=00000", errs_a); tests_failed++; end
      @(negedge clk);
      tests_run++; if (done_a !== 1'b0) begin $display("FAIL sorted_pulse got=%b exp=0", done_a); tests_failed++; end
   endtask

   task automatic test_order();
      in_frame(32'h04010302, 4, 1'b1);
      out_frame(32'h01030204, 4, 1'b1);
      tests_run++; if ({done_a, ok_a} !== 2'b10) begin $display("FAIL order_done_ok got=%b exp=10", {done_a, ok_a}); tests_failed++; end
      tests_run++; if (errs_a !== 5'b10000) begin $display("FAIL order_errs got=%b exp=10000", errs_a); tests_failed++; end
      tests_run++; if ({chk_a, fail_a} !== {16'd2, 16'd1}) begin $display("FAIL order_counters got=%h exp=00020001", {chk_a, fail_a}); tests_failed++; end
   endtask

   task automatic test_sum();
      do_reset();
      in_frame(32'h04010302, 4, 1'b1);
      out_frame(32'h01020305, 4, 1'b1);
      tests_run++; if ({done_a, ok_a} !== 2'b10) begin $display("FAIL sum_done_ok got=%b exp=10", {done_a, ok_a}); tests_failed++; end
      tests_run++; if (errs_a !== 5'b00010) begin $display("FAIL sum_errs got=%b exp=00010", errs_a); tests_failed++; end
   endtask

   task automatic test_len();
      do_reset();
      in_frame(32'h01020300, 3, 1'b1);
      out_frame(32'h01020300, 3, 1'b1);
      tests_run++; if ({done_a, ok_a} !== 2'b10) begin $display("FAIL len_short_done_ok got=%b exp=10", {done_a, ok_a}); tests_failed++; end
      tests_run++; if (errs_a !== 5'b01100) begin $display("FAIL len_errs got=%b exp=01100", errs_a); tests_failed++; end
      in_frame(32'h01010202, 4, 1'b1);
      out_frame(32'h01010202, 4, 1'b1);
      tests_run++; if ({done_a, ok_a} !== 2'b11) begin $display("FAIL len_next_done_ok got=%b exp=11", {done_a, ok_a}); tests_failed++; end
      tests_run++; if ({chk_a, fail_a} !== {16'd2, 16'd1}) begin $display("FAIL len_counters got=%h exp=00020001", {chk_a, fail_a}); tests_failed++; end
   endtask

   task automatic test_fifo_ovf();
      logic [31:0] frames [4];
      frames[0] = 32'h01020304; frames[1] = 32'h00000001;
      frames[2] = 32'h05050505; frames[3] = 32'h02020202;
      do_reset();
      // First frame closes on its 4th beat without tlast.
      in_frame(frames[0], 4, 1'b0);
      for (int f = 1; f < 4; f++) in_frame(frames[f], 4, 1'b1);
      tests_run++; if (ef_a !== 1'b0) begin $display("FAIL fifo_full_no_ovf got=%b exp=0", ef_a); tests_failed++; end
      in_frame(32'h09090909, 4, 1'b1);
      tests_run++; if (ef_a !== 1'b1) begin $display("FAIL fifo_ovf got=%b exp=1", ef_a); tests_failed++; end
      for (int f = 0; f < 4; f++) begin
         out_frame(frames[f], 4, 1'b1);
         tests_run++; if ({done_a, ok_a} !== 2'b11) begin $display("FAIL fifo_frame%0d_done_ok got=%b exp=11", f, {done_a, ok_a}); tests_failed++; end
      end
      tests_run++; if ({chk_a, fail_a} !== {16'd4, 16'd0}) begin $display("FAIL fifo_counters got=%h exp=00040000", {chk_a, fail_a}); tests_failed++; end
      tests_run++; if (errs_a !== 5'b01001) begin $display("FAIL fifo_errs got=%b exp=01001", errs_a); tests_failed++; end
   endtask

   task automatic test_back_to_back();
      do_reset();
      both_frame(32'h04010302, 32'h01020304);
      tests_run++; if ({done_a, ok_a, es_a} !== 3'b110) begin $display("FAIL bypass_done_ok_sum got=%b exp=110", {done_a, ok_a, es_a}); tests_failed++; end
      // The bypassed sum must not remain queued.
      out_frame(32'h01020304, 4, 1'b1);
      tests_run++; if ({done_a, ok_a, es_a} !== 3'b101) begin $display("FAIL empty_pop_done_ok_sum got=%b exp=101", {done_a, ok_a, es_a}); tests_failed++; end
   endtask

   task automatic test_desc_signed();
      do_reset();
      in_frame(32'h80FF0005, 4, 1'b1);
      out_frame(32'h0500FF80, 4, 1'b1);
      tests_run++; if ({done_b, ok_b} !== 2'b11) begin $display("FAIL desc_done_ok got=%b exp=11", {done_b, ok_b}); tests_failed++; end
      tests_run++; if (errs_b !== 5'b00000) begin $display("FAIL desc_errs got=%b exp=00000", errs_b); tests_failed++; end
      // Partial ascending frame to raise err_order before a mid-frame reset.
      beat(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0);
      beat(1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0);
      idle();
      tests_run++; if (eo_b !== 1'b1) begin $display("FAIL desc_midframe_order got=%b exp=1", eo_b); tests_failed++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++; if ({done_b, ok_b, errs_b} !== 7'b0) begin $display("FAIL desc_rst_flags got=%b exp=0000000", {done_b, ok_b, errs_b}); tests_failed++; end
      tests_run++; if ({chk_b, fail_b} !== 32'h0) begin $display("FAIL desc_rst_counters got=%h exp=0", {chk_b, fail_b}); tests_failed++; end
      both_frame(32'h80FF0005, 32'h0500FF80);
      tests_run++; if ({done_b, ok_b, chk_b} !== {2'b11, 16'd1}) begin $display("FAIL desc_after_rst got=%h exp=30001", {done_b, ok_b, chk_b}); tests_failed++; end
   endtask

   initial begin
      test_reset();
      test_sorted();
      test_order();
      test_sum();
      test_len();
      test_fifo_ovf();
      test_back_to_back();
      test_desc_signed();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
